line_follow_ctrl: RTL and testbench

Parametrised line-following motor controller: the next generation of the Pico motor driver. It samples an N-wide reflective sensor bar, filters it, and runs a steering state machine with last-side memory and a bounded search. It latches over-current faults from the H-bridge comparators and drives the 4-bit H-bridge control pins, PWM-gated when configured. It sits between the sensor header (JB) and the H-bridge header (JA).

---
 rtl/line_follow_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_line_follow_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_follow_ctrl.sv
// Line-following motor controller: synchronised + filtered sensor bar, steering FSM, fault latch.
// Optional PWM gating of the H-bridge pins when MOTOR_PWM_EN is defined.
module line_follow_ctrl #(
  parameter int SENSORS       = 3,
  parameter int FILTER_CYCLES = 16,
  parameter int SEARCH_CYCLES = 50_000_000,
  parameter int PWM_BITS      = 8,
  parameter int FWD_DUTY      = 200,
  parameter int TURN_DUTY     = 140
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               fault_clr,
  input  logic               compA,
  input  logic               compB,
  input  logic [SENSORS-1:0] sensors_n,
  output logic [3:0]         direction,
  output logic [3:0]         JA,
  output logic [2:0]         state,
  output logic               lost,
  output logic               fault
);

  localparam int C   = (SENSORS - 1) / 2;
  localparam int FCW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int SCW = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;
  localparam logic [FCW-1:0] F_LAST = FCW'(FILTER_CYCLES - 1);
  localparam logic [SCW-1:0] S_LAST = SCW'(SEARCH_CYCLES - 1);

  localparam logic [3:0] CMD_STOP  = 4'b0000;
  localparam logic [3:0] CMD_FWD   = 4'b1001;
  localparam logic [3:0] CMD_LEFT  = 4'b1010;
  localparam logic [3:0] CMD_RIGHT = 4'b0101;

  generate
    if ((SENSORS % 2) == 0 || SENSORS < 3 || SENSORS > 15 || FILTER_CYCLES < 1 ||
        FILTER_CYCLES > 65535 || SEARCH_CYCLES < 1 || PWM_BITS < 1 ||
        FWD_DUTY < 0 || TURN_DUTY < 0) begin : g_bad_param
      $error("line_follow_ctrl: illegal parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FOLLOW = 3'd1,
    ST_SEARCH = 3'd2,
    ST_LOST   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {CL_NONE, CL_FWD, CL_LEFT, CL_RIGHT} class_t;

  logic [SENSORS-1:0] sens_s1_q, sens_s2_q;
  logic [1:0]         comp_s1_q, comp_s2_q;
  logic [SENSORS-1:0] cand_q, filt_q, filt_d;
  logic [FCW-1:0]     fcnt_q, fcnt_d;
  state_t             state_q, state_d;
  logic [SCW-1:0]     scnt_q, scnt_d;
  logic               last_q, last_d;
  logic [3:0]         dir_q, dir_d;
  logic               lost_q, fault_q;
  class_t             cls;
  logic [SENSORS-1:0] det;
  logic               l_any, r_any;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sens_s1_q <= '1;
      sens_s2_q <= '1;
      comp_s1_q <= 2'b11;
      comp_s2_q <= 2'b11;
      cand_q    <= '1;
      filt_q    <= '1;
      fcnt_q    <= '0;
    end else begin
      sens_s1_q <= sensors_n;
      sens_s2_q <= sens_s1_q;
      comp_s1_q <= {compA, compB};
      comp_s2_q <= comp_s1_q;
      cand_q    <= sens_s2_q;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
    end
  end

  // The count is taken on the next-state value so acceptance lands on the Nth identical sample.
  always_comb begin
    filt_d = filt_q;
    if (sens_s2_q != cand_q)
      fcnt_d = '0;
    else if (fcnt_q == F_LAST)
      fcnt_d = fcnt_q;
    else
      fcnt_d = fcnt_q + 1'b1;
    if (fcnt_d == F_LAST)
      filt_d = sens_s2_q;
  end

  always_comb begin
    det   = ~filt_q;
    l_any = 1'b0;
    r_any = 1'b0;
    for (int i = 0; i < SENSORS; i++) begin
      if (i > C) l_any = l_any | det[i];
      if (i < C) r_any = r_any | det[i];
    end
    if (det[C])             cls = CL_FWD;
    else if (l_any && !r_any) cls = CL_LEFT;
    else if (r_any && !l_any) cls = CL_RIGHT;
    else if (l_any && r_any)  cls = CL_FWD;
    else                      cls = CL_NONE;
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    last_d  = last_q;
    dir_d   = CMD_STOP;
    if (comp_s2_q != 2'b11) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (fault_clr) state_d = ST_IDLE;
    end else if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_FOLLOW;
        ST_FOLLOW: begin
          if (cls == CL_NONE) begin
            state_d = ST_SEARCH;
            scnt_d  = '0;
          end
        end
        ST_SEARCH: begin
          if (cls != CL_NONE)
            state_d = ST_FOLLOW;
          else if (scnt_q == S_LAST)
            state_d = ST_LOST;
          else
            scnt_d = scnt_q + 1'b1;
        end
        ST_LOST:   if (cls != CL_NONE) state_d = ST_FOLLOW;
        default:   state_d = ST_IDLE;
      endcase
    end

    if (state_d == ST_FOLLOW) begin
      case (cls)
        CL_FWD:   dir_d = CMD_FWD;
        CL_LEFT:  begin dir_d = CMD_LEFT;  last_d = 1'b1; end
        CL_RIGHT: begin dir_d = CMD_RIGHT; last_d = 1'b0; end
        default:  dir_d = CMD_STOP;
      endcase
    end else if (state_d == ST_SEARCH) begin
      dir_d = last_q ? CMD_LEFT : CMD_RIGHT;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      scnt_q  <= '0;
      last_q  <= 1'b0;
      dir_q   <= CMD_STOP;
      lost_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      lost_q  <= (state_d == ST_LOST);
      fault_q <= (state_d == ST_FAULT);
    end
  end

  assign direction = dir_q;
  assign state     = state_q;
  assign lost      = lost_q;
  assign fault     = fault_q;

`ifdef MOTOR_PWM_EN
  localparam int PWM_MAX = (2 ** PWM_BITS) - 1;
  localparam logic [PWM_BITS-1:0] FWD_ON  = PWM_BITS'((FWD_DUTY  > PWM_MAX) ? PWM_MAX : FWD_DUTY);
  localparam logic [PWM_BITS-1:0] TURN_ON = PWM_BITS'((TURN_DUTY > PWM_MAX) ? PWM_MAX : TURN_DUTY);

  logic [PWM_BITS-1:0] pwm_q;
  logic [PWM_BITS-1:0] duty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pwm_q <= '0;
    else        pwm_q <= pwm_q + 1'b1;
  end

  always_comb begin
    case (dir_q)
      CMD_FWD:            duty = FWD_ON;
      CMD_LEFT, CMD_RIGHT: duty = TURN_ON;
      default:            duty = '0;
    endcase
  end

  assign JA = (pwm_q < duty) ? dir_q : CMD_STOP;
`else
  assign JA = dir_q;
`endif

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Self-checking bench for line_follow_ctrl: directed scenarios plus random stimulus
// compared cycle by cycle against a behavioural model built from sample histories.
module tb_line_follow_ctrl;
  localparam int NS = 3;
  localparam int FC = 4;
  localparam int SC = 100;
  localparam int PB = 4;
  localparam int FD = 12;
  localparam int TD = 7;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic fault_clr = 1'b0;
  logic compA = 1'b1;
  logic compB = 1'b1;
  logic [NS-1:0] sensors_n = '1;
  logic [3:0] direction, JA;
  logic [2:0] state;
  logic lost, fault;

  logic [4:0] sensors5 = '1;
  logic [3:0] dir5, ja5;
  logic [2:0] state5;
  logic lost5, fault5;

  int errors = 0;
  int checks = 0;

  line_follow_ctrl #(.SENSORS(NS), .FILTER_CYCLES(FC), .SEARCH_CYCLES(SC),
                     .PWM_BITS(PB), .FWD_DUTY(FD), .TURN_DUTY(TD)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .fault_clr(fault_clr),
    .compA(compA), .compB(compB), .sensors_n(sensors_n),
    .direction(direction), .JA(JA), .state(state), .lost(lost), .fault(fault));

  line_follow_ctrl #(.SENSORS(5), .FILTER_CYCLES(FC), .SEARCH_CYCLES(SC)) u_dut5 (
    .clock(clock), .reset(reset), .enable(enable), .fault_clr(fault_clr),
    .compA(compA), .compB(compB), .sensors_n(sensors5),
    .direction(dir5), .JA(ja5), .state(state5), .lost(lost5), .fault(fault5));

  always #5 clock = ~clock;

  wire [12:0] obs = {state, direction, lost, fault, JA};

  // ---------------- behavioural model ----------------
  int         m_state;   // 0 idle, 1 follow, 2 search, 3 lost, 4 fault
  logic [3:0] m_dir;
  logic [3:0] m_ja;
  bit         m_last;
  int         m_sage;    // cycles spent in SEARCH so far
  int         m_tick;
  logic [NS-1:0] m_filt;
  logic [NS-1:0] hs[$];
  bit         hca[$];
  bit         hcb[$];

  // 0 none, 1 forward, 2 left, 3 right
  function automatic int classify(input logic [14:0] filt_n, input int n);
    logic [14:0] d;
    bit l, r;
    int c;
    d = ~filt_n;
    c = (n - 1) / 2;
    l = 0;
    r = 0;
    for (int i = 0; i < n; i++) begin
      if (d[i] && i > c) l = 1;
      if (d[i] && i < c) r = 1;
    end
    if (d[c]) return 1;
    if (l && !r) return 2;
    if (r && !l) return 3;
    if (l && r) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] cmd(input int cls);
    case (cls)
      1: return 4'b1001;
      2: return 4'b1010;
      3: return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [12:0] model_vec();
    return {3'(m_state), m_dir, (m_state == 3), (m_state == 4), m_ja};
  endfunction

  task automatic model_init();
    m_state = 0; m_dir = 4'b0000; m_ja = 4'b0000; m_last = 0; m_sage = 0; m_tick = 0;
    m_filt = '1;
    hs.delete(); hca.delete(); hcb.delete();
    for (int i = 0; i < 8; i++) begin
      hs.push_back('1); hca.push_back(1'b1); hcb.push_back(1'b1);
    end
  endtask

  task automatic model_step();
    int cls, ns, duty, n;
    bit same;
    logic [NS-1:0] v;
    hs.push_back(sensors_n); hca.push_back(compA); hcb.push_back(compB);
    n = hs.size();
    cls = classify({{(15-NS){1'b1}}, m_filt}, NS);
    if (!(hca[n-3] && hcb[n-3]))      ns = 4;
    else if (m_state == 4)           ns = fault_clr ? 0 : 4;
    else if (!enable)                ns = 0;
    else if (m_state == 0)           ns = 1;
    else if (m_state == 1)           ns = (cls == 0) ? 2 : 1;
    else if (m_state == 2)           ns = (cls != 0) ? 1 : ((m_sage >= SC) ? 3 : 2);
    else                             ns = (cls != 0) ? 1 : 3;
    if (ns == 2) m_sage = (m_state == 2) ? m_sage + 1 : 1;
    if (ns == 1)      m_dir = cmd(cls);
    else if (ns == 2) m_dir = m_last ? 4'b1010 : 4'b0101;
    else              m_dir = 4'b0000;
    if (ns == 1 && cls == 2) m_last = 1;
    if (ns == 1 && cls == 3) m_last = 0;
    m_state = ns;
    // filt follows the sample stream once FC consecutive samples agree
    v = hs[n-3];
    same = 1;
    for (int j = 0; j < FC; j++) if (hs[n-3-j] !== v) same = 0;
    if (same) m_filt = v;
    while (hs.size() > 16) begin
      void'(hs.pop_front()); void'(hca.pop_front()); void'(hcb.pop_front());
    end
    m_tick++;
`ifdef MOTOR_PWM_EN
    duty = (m_dir == 4'b1001) ? FD : ((m_dir == 4'b1010 || m_dir == 4'b0101) ? TD : 0);
    m_ja = ((m_tick % (1 << PB)) < duty) ? m_dir : 4'b0000;
`else
    duty = 0;
    m_ja = m_dir;
`endif
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) model_init();
    else        model_step();
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; sensors_n = '1;
    repeat (3) @(negedge clock);
    checks++;
    if (obs !== 13'd0) begin errors++; $display("FAIL reset_values dut=%b exp=%b", obs, 13'd0); end
    reset = 1'b1; enable = 1'b1;
    @(negedge clock);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL reset_to_follow state=%0d exp=1", state); end
    @(negedge clock);
    checks++;
    if (state !== 3'd2 || direction !== 4'b0101) begin
      errors++; $display("FAIL enter_search state=%0d dir=%b exp=2/0101", state, direction);
    end
    for (int k = 0; k < 104; k++) begin
      @(negedge clock);
      checks++;
      if (obs !== model_vec()) begin errors++; $display("FAIL search_model k=%0d dut=%b exp=%b", k, obs, model_vec()); end
    end
    checks++;
    if (state !== 3'd3 || lost !== 1'b1 || direction !== 4'b0000) begin
      errors++; $display("FAIL search_timeout state=%0d lost=%b dir=%b exp=3/1/0000", state, lost, direction);
    end
  endtask

  task automatic test_filter();
    int first_k;
    first_k = 0;
    sensors_n = 3'b101;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      checks++;
      if (obs !== model_vec()) begin errors++; $display("FAIL filter_model k=%0d dut=%b exp=%b", k, obs, model_vec()); end
      if (first_k == 0 && direction === 4'b1001) first_k = k;
    end
    checks++;
    if (first_k !== 7) begin errors++; $display("FAIL filter_latency got=%0d exp=7", first_k); end
    sensors_n = 3'b110;
    repeat (3) @(negedge clock);
    sensors_n = 3'b101;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      checks++;
      if (direction !== 4'b1001 || obs !== model_vec()) begin
        errors++; $display("FAIL glitch_reject k=%0d dut=%b exp=%b", k, obs, model_vec());
      end
    end
  endtask

  task automatic test_left_search();
    logic [NS-1:0] pat [3];
    logic [3:0] dexp [3];
    logic [2:0] sexp [3];
    pat[0] = 3'b011; dexp[0] = 4'b1010; sexp[0] = 3'd1;
    pat[1] = 3'b111; dexp[1] = 4'b1010; sexp[1] = 3'd2;
    pat[2] = 3'b101; dexp[2] = 4'b1001; sexp[2] = 3'd1;
    for (int p = 0; p < 3; p++) begin
      sensors_n = pat[p];
      for (int k = 0; k < 9; k++) begin
        @(negedge clock);
        checks++;
        if (obs !== model_vec()) begin errors++; $display("FAIL left_model p=%0d k=%0d dut=%b exp=%b", p, k, obs, model_vec()); end
      end
      checks++;
      if (direction !== dexp[p] || state !== sexp[p]) begin
        errors++; $display("FAIL left_search p=%0d dir=%b state=%0d exp=%b/%0d", p, direction, state, dexp[p], sexp[p]);
      end
    end
  endtask

  task automatic test_ja();
    int on_cnt, exp_on;
    on_cnt = 0;
`ifdef MOTOR_PWM_EN
    exp_on = FD;
`else
    exp_on = 16;
`endif
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      checks++;
      if (obs !== model_vec()) begin errors++; $display("FAIL ja_model k=%0d dut=%b exp=%b", k, obs, model_vec()); end
      if (JA === 4'b1001) on_cnt++;
    end
    checks++;
    if (on_cnt !== exp_on) begin errors++; $display("FAIL ja_on_count got=%0d exp=%0d", on_cnt, exp_on); end
  endtask

  task automatic test_five();
    logic [4:0] pat;
    int cls;
    pat = 5'b01110;
    for (int t = 0; t < 7; t++) begin
      sensors5 = pat;
      cls = classify({10'h3ff, pat}, 5);
      repeat (10) @(negedge clock);
      checks++;
      if (dir5 !== cmd(cls) || state5 !== 3'd1) begin
        errors++; $display("FAIL five_wide pat=%b dir=%b state=%0d exp=%b/1", pat, dir5, state5, cmd(cls));
      end
      do pat = 5'($urandom_range(0, 30)); while (classify({10'h3ff, pat}, 5) == 0);
    end
    sensors5 = 5'b01110;
  endtask

  task automatic test_fault();
    compB = 1'b0;
    @(negedge clock); compB = 1'b1;
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL fault_early1 fault=%b exp=0", fault); end
    @(negedge clock);
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL fault_early2 fault=%b exp=0", fault); end
    @(negedge clock);
    checks++;
    if (fault !== 1'b1 || direction !== 4'b0000 || state !== 3'd4) begin
      errors++; $display("FAIL fault_latency fault=%b dir=%b state=%0d exp=1/0000/4", fault, direction, state);
    end
    compB = 1'b0;
    repeat (4) @(negedge clock);
    fault_clr = 1'b1;
    @(negedge clock); fault_clr = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (state !== 3'd4 || obs !== model_vec()) begin
      errors++; $display("FAIL clr_while_low dut=%b exp=%b", obs, model_vec());
    end
    compB = 1'b1;
    repeat (3) @(negedge clock);
    fault_clr = 1'b1;
    @(negedge clock); fault_clr = 1'b0;
    checks++;
    if (state !== 3'd0 || fault !== 1'b0) begin errors++; $display("FAIL clr_to_idle state=%0d fault=%b exp=0/0", state, fault); end
    @(negedge clock);
    checks++;
    if (state !== 3'd1 || direction !== 4'b1001 || obs !== model_vec()) begin
      errors++; $display("FAIL idle_to_follow dut=%b exp=%b", obs, model_vec());
    end
  endtask

  task automatic test_async_reset();
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 13'd0) begin errors++; $display("FAIL async_reset dut=%b exp=%b", obs, 13'd0); end
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clock);
      checks++;
      if (obs !== model_vec()) begin errors++; $display("FAIL random_model k=%0d dut=%b exp=%b", k, obs, model_vec()); end
      if (hold == 0) begin
        sensors_n = NS'($urandom_range(0, 7));
        hold = $urandom_range(1, 9);
      end else hold--;
      compA = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      compB = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      fault_clr = ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0;
      enable = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
    end
    compA = 1'b1; compB = 1'b1; fault_clr = 1'b0; enable = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_filter();
    test_left_search();
    test_ja();
    test_five();
    test_fault();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
